// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU controller: op codes and FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    // Op codes. Bit 2 also selects B inversion and the initial carry-in of the slice.
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/nibble_serial_alu_ctrl.sv
// Sequences a WIDTH-bit ALU op through an external 4-bit slice, LS nibble first.
// Latency: out_valid rises WIDTH/4 edges after the accept edge; one op per WIDTH/4+2 cycles.
// Backpressure: result held stable in DONE until out_ready; in_ready only asserted in IDLE.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready/in_a/in_b/in_op request handshake and operands
//   out_valid/out_ready/out_*        result handshake, result and flags
//   alu_a/alu_b/alu_op/alu_cin/alu_less  drive the external 4-bit slice
//   alu_result/alu_cout/alu_set/alu_overflow  slice response
// Optional: define OP_CHECK_EN to add out_illegal and short-circuit illegal op codes.
module nibble_serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 16   // multiple of 4, at least 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_cout,
    output logic             out_overflow,
`ifdef OP_CHECK_EN
    output logic             out_illegal,
`endif
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_cin,
    output logic             alu_less,
    input  logic [3:0]       alu_result,
    input  logic             alu_cout,
    input  logic             alu_set,
    input  logic             alu_overflow
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2:0]           op_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 carry_q;
    logic [WIDTH-1:0]     result_q;
    logic                 zero_q, cout_q, ovf_q;
    logic                 accept, last, skip_run;
    logic [WIDTH-1:0]     merged, final_result;

`ifdef OP_CHECK_EN
    logic illegal_q;
    assign skip_run    = !op_is_legal(in_op);
    assign out_illegal = illegal_q;
`else
    assign skip_run = 1'b0;
`endif

    assign out_valid    = (state_q == DONE);
    assign out_result   = result_q;
    assign out_zero     = zero_q;
    assign out_cout     = cout_q;
    assign out_overflow = ovf_q;
    assign alu_less     = 1'b0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake and slice drive
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        last     = 1'b0;
        alu_a    = 4'h0;
        alu_b    = 4'h0;
        alu_op   = 3'b000;
        alu_cin  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = skip_run ? DONE : RUN;
                end
            end
            RUN: begin
                alu_a   = a_q[{idx_q, 2'b00} +: 4];
                alu_b   = b_q[{idx_q, 2'b00} +: 4];
                alu_op  = op_q;
                alu_cin = carry_q;
                if (idx_q == LAST_IDX) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result assembly: splice the slice output into the current nibble; SLT replaces
    // the whole word with the sign of the final subtraction.
    always_comb begin
        merged = result_q;
        merged[{idx_q, 2'b00} +: 4] = alu_result;
        final_result = (op_q == OP_SLT) ? WIDTH'(alu_set) : merged;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'b000;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef OP_CHECK_EN
            illegal_q <= 1'b0;
`endif
        end else if (accept) begin
            a_q      <= in_a;
            b_q      <= in_b;
            op_q     <= in_op;
            idx_q    <= '0;
            carry_q  <= in_op[2];   // +1 completes the two's complement for SUB/SLT
            result_q <= '0;
            zero_q   <= skip_run;   // an illegal op reports a zero result
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef OP_CHECK_EN
            illegal_q <= skip_run;
`endif
        end else if (state_q == RUN) begin
            carry_q <= alu_cout;
            idx_q   <= idx_q + 1'b1;
            if (last) begin
                result_q <= final_result;
                zero_q   <= (final_result == '0);
                cout_q   <= alu_cout;
                ovf_q    <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_overflow : 1'b0;
            end else begin
                result_q <= merged;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Directed bench for nibble_serial_alu_ctrl with a behavioural 4-bit slice attached.
// Latency: n/a (testbench).
// Backpressure: exercised by holding out_ready low while a result is pending.
module tb_nibble_serial_alu_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] in_a, in_b;
    logic [2:0]  in_op;
    logic        out_valid, out_ready;
    logic [15:0] out_result;
    logic        out_zero, out_cout, out_overflow;
`ifdef OP_CHECK_EN
    logic        out_illegal;
`endif
    logic [3:0]  alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_cin, alu_less, alu_cout, alu_set, alu_overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nibble_serial_alu_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero),
        .out_cout(out_cout), .out_overflow(out_overflow),
`ifdef OP_CHECK_EN
        .out_illegal(out_illegal),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_cin(alu_cin), .alu_less(alu_less),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .alu_set(alu_set), .alu_overflow(alu_overflow)
    );

    // Behavioural 4-bit slice: op[2] inverts B, op[1:0] selects AND/OR/ADD/LESS.
    logic [3:0] bb;
    logic [4:0] sum5;
    logic [3:0] low4;
    always_comb begin
        bb           = alu_op[2] ? ~alu_b : alu_b;
        sum5         = {1'b0, alu_a} + {1'b0, bb} + {4'b0, alu_cin};
        low4         = {1'b0, alu_a[2:0]} + {1'b0, bb[2:0]} + {3'b0, alu_cin};
        alu_cout     = sum5[4];
        alu_set      = sum5[3];
        alu_overflow = low4[3] ^ sum5[4];
        case (alu_op[1:0])
            2'b00:   alu_result = alu_a & bb;
            2'b01:   alu_result = alu_a | bb;
            2'b10:   alu_result = sum5[3:0];
            default: alu_result = {3'b000, alu_less};
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        for (int n = 0; n < 50 && !in_ready; n++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL issue_in_ready_timeout got=%b exp=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_result !== 16'h0000) begin failures++; $display("FAIL rst_result got=%h exp=0000", out_result); end
        checks++; if ({out_zero, out_cout, out_overflow} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {out_zero, out_cout, out_overflow}); end
        checks++; if ({alu_a, alu_b, alu_op, alu_cin, alu_less} !== 13'h0) begin failures++; $display("FAIL rst_alu_drive got=%h exp=0", {alu_a, alu_b, alu_op, alu_cin, alu_less}); end
    endtask

    task automatic test_add();
        int e;
        issue(16'h00FF, 16'h0001, OP_ADD);
        checks++; if ({alu_a, alu_b, alu_op, alu_cin} !== {4'hF, 4'h1, OP_ADD, 1'b0}) begin failures++; $display("FAIL add_slice_drive got=%h exp=%h", {alu_a, alu_b, alu_op, alu_cin}, {4'hF, 4'h1, OP_ADD, 1'b0}); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL add_in_ready_run got=%b exp=0", in_ready); end
        wait_done(e);
        checks++; if (e !== 4) begin failures++; $display("FAIL add_latency got=%0d exp=4", e); end
        checks++; if (out_result !== 16'h0100) begin failures++; $display("FAIL add_result got=%h exp=0100", out_result); end
        checks++; if ({out_zero, out_cout, out_overflow} !== 3'b000) begin failures++; $display("FAIL add_flags got=%b exp=000", {out_zero, out_cout, out_overflow}); end
        checks++; if ({alu_a, alu_b, alu_op, alu_cin} !== 12'h0) begin failures++; $display("FAIL add_done_drive got=%h exp=0", {alu_a, alu_b, alu_op, alu_cin}); end
        consume();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL add_after_consume got=%b exp=01", {out_valid, in_ready}); end
    endtask

    task automatic test_sub();
        int e;
        issue(16'h8000, 16'h0001, OP_SUB);
        checks++; if (alu_cin !== 1'b1) begin failures++; $display("FAIL sub_first_cin got=%b exp=1", alu_cin); end
        wait_done(e);
        checks++; if (out_result !== 16'h7FFF) begin failures++; $display("FAIL sub1_result got=%h exp=7fff", out_result); end
        checks++; if ({out_zero, out_cout, out_overflow} !== 3'b011) begin failures++; $display("FAIL sub1_flags got=%b exp=011", {out_zero, out_cout, out_overflow}); end
        consume();
        issue(16'h1234, 16'h1234, OP_SUB);
        wait_done(e);
        checks++; if (out_result !== 16'h0000) begin failures++; $display("FAIL sub2_result got=%h exp=0000", out_result); end
        checks++; if ({out_zero, out_cout, out_overflow} !== 3'b110) begin failures++; $display("FAIL sub2_flags got=%b exp=110", {out_zero, out_cout, out_overflow}); end
        consume();
    endtask

    task automatic test_slt();
        int e;
        issue(16'hFFFF, 16'h0001, OP_SLT);
        wait_done(e);
        checks++; if (out_result !== 16'h0001) begin failures++; $display("FAIL slt1_result got=%h exp=0001", out_result); end
        checks++; if ({out_zero, out_overflow} !== 2'b00) begin failures++; $display("FAIL slt1_flags got=%b exp=00", {out_zero, out_overflow}); end
        consume();
        issue(16'h0005, 16'h0003, OP_SLT);
        wait_done(e);
        checks++; if (out_result !== 16'h0000) begin failures++; $display("FAIL slt2_result got=%h exp=0000", out_result); end
        checks++; if ({out_zero, out_overflow} !== 2'b10) begin failures++; $display("FAIL slt2_flags got=%b exp=10", {out_zero, out_overflow}); end
        consume();
    endtask

    task automatic test_back_to_back();
        int e;
        issue(16'hF0F0, 16'h3C3C, OP_AND);
        wait_done(e);
        checks++; if (out_result !== 16'h3030) begin failures++; $display("FAIL and_result got=%h exp=3030", out_result); end
        for (int i = 0; i < 3; i++) begin
            in_valid = (i != 1);
            in_a = 16'hFFFF; in_b = 16'hFFFF; in_op = OP_ADD;
            @(posedge clk); #1;
            checks++; if ({out_valid, in_ready} !== 2'b10) begin failures++; $display("FAIL hold_handshake cyc=%0d got=%b exp=10", i, {out_valid, in_ready}); end
            checks++; if ({out_result, out_zero, out_overflow} !== {16'h3030, 2'b00}) begin failures++; $display("FAIL hold_outputs cyc=%0d got=%h exp=%h", i, {out_result, out_zero, out_overflow}, {16'h3030, 2'b00}); end
        end
        // Release the AND result while the OR request is already waiting.
        in_a = 16'hF0F0; in_b = 16'h3C3C; in_op = OP_OR; in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL b2b_idle got=%b exp=01", {out_valid, in_ready}); end
        issue(16'hF0F0, 16'h3C3C, OP_OR);
        wait_done(e);
        checks++; if (e !== 4) begin failures++; $display("FAIL or_latency got=%0d exp=4", e); end
        checks++; if ({out_result, out_zero} !== {16'hFCFC, 1'b0}) begin failures++; $display("FAIL or_result got=%h exp=%h", {out_result, out_zero}, {16'hFCFC, 1'b0}); end
        consume();
    endtask

    task automatic test_reset_mid_run();
        int e;
        issue(16'hFFFF, 16'h0001, OP_ADD);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        checks++; if ({out_result, out_zero, out_cout, out_overflow} !== 19'h0) begin failures++; $display("FAIL midrst_outputs got=%h exp=0", {out_result, out_zero, out_cout, out_overflow}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL midrst_release got=%b exp=10", {in_ready, out_valid}); end
        issue(16'h0002, 16'h0003, OP_ADD);
        wait_done(e);
        checks++; if ({out_result, out_zero, out_cout, out_overflow} !== {16'h0005, 3'b000}) begin failures++; $display("FAIL midrst_next_add got=%h exp=%h", {out_result, out_zero, out_cout, out_overflow}, {16'h0005, 3'b000}); end
        consume();
    endtask

`ifdef OP_CHECK_EN
    task automatic test_illegal();
        int e;
        issue(16'h1234, 16'h5678, 3'b011);
        wait_done(e);
        checks++; if (e !== 0) begin failures++; $display("FAIL illegal_latency got=%0d extra edges exp=0", e); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL illegal_out_valid got=%b exp=1", out_valid); end
        checks++; if ({out_illegal, out_result, out_zero, out_cout, out_overflow} !== {1'b1, 16'h0000, 3'b100}) begin failures++; $display("FAIL illegal_outputs got=%h exp=%h", {out_illegal, out_result, out_zero, out_cout, out_overflow}, {1'b1, 16'h0000, 3'b100}); end
        consume();
        issue(16'h0001, 16'h0001, OP_ADD);
        wait_done(e);
        checks++; if ({out_illegal, out_result} !== {1'b0, 16'h0002}) begin failures++; $display("FAIL legal_after_illegal got=%h exp=%h", {out_illegal, out_result}, {1'b0, 16'h0002}); end
        consume();
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = '0;
        #12;
        test_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_add();
        test_sub();
        test_slt();
        test_back_to_back();
        test_reset_mid_run();
`ifdef OP_CHECK_EN
        test_illegal();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_serial_alu_ctrl.md
Name: nibble_serial_alu_ctrl

Overview:
- Sequencer that computes a WIDTH-bit ALU operation by driving one external 4-bit ALU slice for WIDTH/4 consecutive cycles, least-significant nibble first.
- Ripples the slice carry through a register and assembles the result, zero, overflow and carry-out flags.
- Sits directly upstream of the 4-bit slice and owns its operand, op and carry inputs.
- Upstream requester and downstream consumer use valid/ready handshakes.

Parameters:
- WIDTH, 16: operand and result width. Must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4: derived; number of slice passes. Not overridable.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  controller can accept a request.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  operation code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  final result.
- out_zero  output  1  out_result == 0.
- out_cout  output  1  carry out of the MSB nibble.
- out_overflow  output  1  signed overflow (ADD/SUB only, else 0).
- alu_a  output  4  slice operand A nibble.
- alu_b  output  4  slice operand B nibble.
- alu_op  output  3  slice op.
- alu_cin  output  1  slice carry in.
- alu_less  output  1  slice less input, tied 0.
- alu_result  input  4  slice result.
- alu_cout  input  1  slice carry out.
- alu_set  input  1  slice MSB adder sign.
- alu_overflow  input  1  slice overflow.

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- While reset is asserted, all registers clear:
  - state = IDLE.
  - out_valid, out_result, out_zero, out_cout and out_overflow = 0.
  - Nibble index and carry register = 0.
- States:
  - IDLE: in_ready = 1. in_valid & in_ready latches in_a, in_b and in_op, loads nibble index 0 and carry = op[2], then goes to RUN.
  - RUN: in_ready = 0. Each cycle the slice is driven combinationally from registers:
    - alu_a / alu_b = current nibble of the latched operands.
    - alu_op = latched op.
    - alu_cin = carry register.
  - On each RUN edge:
    - alu_result is written into result nibble [index].
    - carry <= alu_cout.
    - index increments.
  - On the edge where index == NIBBLES-1, the controller also captures the final flags and goes to DONE:
    - cout = alu_cout.
    - overflow = alu_overflow if op is ADD or SUB, else 0.
    - set = alu_set.
  - DONE: out_valid = 1. out_valid & out_ready returns to IDLE.
- Outputs are stable while out_valid = 1 and out_ready = 0.
- SLT: the final out_result is {WIDTH-1 zeros, set}, and out_overflow = 0.
- out_zero is computed on the final out_result, including after SLT substitution.
- Latency: out_valid rises NIBBLES edges after the accept edge (4 for WIDTH = 16). Throughput is one op per NIBBLES+2 cycles.
- In IDLE and DONE, alu_a, alu_b, alu_op and alu_cin are driven to 0.
- in_valid is ignored outside IDLE.
- Reset asserted mid-RUN or in DONE aborts the operation with no output. After release the controller is in IDLE with in_ready = 1.
- Carry between nibbles is always the registered alu_cout. The slice must honour alu_cin for every nibble.

Optional Feature:
- Macro OP_CHECK_EN.
- Defined:
  - Adds output port out_illegal (1 bit, reset 0).
  - Accepting an op outside {000, 001, 010, 110, 111} skips RUN and goes IDLE -> DONE in one edge.
  - That result has out_result = 0, out_zero = 1, out_cout = 0, out_overflow = 0 and out_illegal = 1.
  - out_illegal = 0 for legal ops.
- Undefined:
  - No out_illegal port.
  - Illegal ops run through RUN with whatever the slice produces.

Decomposition:
- Shared package alu_pkg holds:
  - Op code localparams: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT.
  - State encoding: IDLE, RUN, DONE.
- The slice is instantiated by the parent, not inside this block.
- No sub-module; nibble select and result assembly are inline.

Test Plan (WIDTH=16, slice instance connected):
- ADD 0x00FF + 0x0001 -> out_result 0x0100, cout 0, overflow 0, zero 0. out_valid rises exactly 4 edges after accept.
- SUB 0x8000 - 0x0001 -> 0x7FFF, overflow 1, cout 1. SUB 0x1234 - 0x1234 -> 0x0000, zero 1, cout 1.
- SLT 0xFFFF vs 0x0001 -> 0x0001, zero 0. SLT 0x0005 vs 0x0003 -> 0x0000, zero 1, overflow 0.
- AND 0xF0F0 & 0x3C3C -> 0x3030, then OR -> 0xFCFC, issued back-to-back. out_ready held low 3 cycles: outputs stable, in_ready 0, in_valid pulses ignored.
- rst_n asserted after 2 RUN edges of ADD 0xFFFF + 0x0001: immediately out_valid 0 and all flags 0. After release in_ready = 1, and the next ADD 0x0002 + 0x0003 -> 0x0005.
- OP_CHECK_EN defined, op 011 -> out_valid 1 edge after accept, out_illegal 1, result 0x0000, zero 1. Op 010 -> out_illegal 0.
